count_seq_ctrl: RTL

//  Sequencer for the shared up/down counter datapath. On start it clears the counter,

---
 rtl/count_seq_pkg.sv | 16 +
 rtl/count_seq_timer.sv | 37 +++
 rtl/count_seq_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/count_seq_pkg.sv
// rtl/count_seq_pkg.sv - state and select encodings for the count sequencer
package count_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_UP   = 3'd2,
        ST_HOLD = 3'd3,
        ST_DOWN = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic SEL_UP   = 1'b0;
    localparam logic SEL_DOWN = 1'b1;

endpackage

// File: rtl/count_seq_timer.sv
// rtl/count_seq_timer.sv - loadable down-counter that times the HOLD dwell
module count_seq_timer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          tick,
    output logic          zero
);

    logic [DW-1:0] timer_q;
    logic [DW-1:0] timer_d;

    // load wins over tick; ticking stops at zero so the timer never wraps
    always_comb begin
        timer_d = timer_q;
        if (load) begin
            timer_d = load_val;
        end else if (tick && (timer_q != '0)) begin
            timer_d = timer_q - DW'(1);
        end
    end

    // timer register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign zero = (timer_q == '0);

endmodule

// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - clear/ramp-up/dwell/ramp-down sequencer for the shared counter
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int bits = 4,
    parameter int DW   = 8,
    parameter int RW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [bits-1:0] limit,
    input  logic [DW-1:0]   dwell,
    input  logic [RW-1:0]   reps,
    input  logic [bits-1:0] count_in,
    output logic            cnt_select,
    output logic            cnt_en,
    output logic            cnt_clr,
    output logic            busy,
    output logic            done,
    output logic [RW-1:0]   rep_cnt
);

    state_t          state_q, state_d;
    logic [bits-1:0] limit_q, limit_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [RW-1:0]   reps_q, reps_d;
    logic [RW-1:0]   rep_cnt_q, rep_cnt_d;

    logic            hold_load;
    logic            hold_tick;
    logic            hold_zero;
    logic [DW-1:0]   hold_load_val;
    logic            rep_end;
    logic [RW:0]     rep_next;
    logic [RW:0]     reps_eff;

    // timer holds (cycles left - 1) so a dwell of 0 still gives one HOLD cycle
    assign hold_load_val = (dwell_q == '0) ? '0 : dwell_q - DW'(1);
    assign rep_next      = {1'b0, rep_cnt_q} + (RW+1)'(1);
    assign reps_eff      = (reps_q == '0) ? (RW+1)'(1) : {1'b0, reps_q};

    count_seq_timer #(
        .DW(DW)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (hold_load_val),
        .tick     (hold_tick),
        .zero     (hold_zero)
    );

    // state, config latches and repetition counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            limit_q   <= '0;
            dwell_q   <= '0;
            reps_q    <= '0;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            dwell_q   <= dwell_d;
            reps_q    <= reps_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    // next state; count_in lags cnt_en by one cycle, so ramps stop one value early
    always_comb begin
        state_d   = state_q;
        limit_d   = limit_q;
        dwell_d   = dwell_q;
        reps_d    = reps_q;
        rep_cnt_d = rep_cnt_q;
        hold_load = 1'b0;
        hold_tick = 1'b0;
        rep_end   = 1'b0;

        if ((state_q != ST_IDLE) && abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        limit_d   = limit;
                        dwell_d   = dwell;
                        reps_d    = reps;
                        rep_cnt_d = '0;
                        state_d   = ST_CLR;
                    end
                end
                ST_CLR: begin
                    if (limit_q == '0) begin
                        state_d   = ST_HOLD;
                        hold_load = 1'b1;
                    end else begin
                        state_d = ST_UP;
                    end
                end
                ST_UP: begin
                    if (count_in == limit_q - bits'(1)) begin
                        state_d   = ST_HOLD;
                        hold_load = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!hold_zero) begin
                        hold_tick = 1'b1;
                    end else if (limit_q != '0) begin
                        state_d = ST_DOWN;
                    end else begin
                        rep_end = 1'b1;
                    end
                end
                ST_DOWN: begin
                    if (count_in == bits'(1)) begin
                        rep_end = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // a zero limit has no ramps, so further repetitions are back-to-back dwells
        if (rep_end) begin
            rep_cnt_d = rep_next[RW-1:0];
            if (rep_next >= reps_eff) begin
                state_d = ST_DONE;
            end else if (limit_q != '0) begin
                state_d = ST_UP;
            end else begin
                state_d   = ST_HOLD;
                hold_load = 1'b1;
            end
        end
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        cnt_select = SEL_UP;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
        busy       = (state_q != ST_IDLE);
        done       = 1'b0;
        case (state_q)
            ST_CLR:  cnt_clr = 1'b1;
            ST_UP:   cnt_en  = 1'b1;
            ST_DOWN: begin
                cnt_en     = 1'b1;
                cnt_select = SEL_DOWN;
            end
            ST_DONE: done = 1'b1;
            default: begin
                cnt_en = 1'b0;
            end
        endcase
    end

    assign rep_cnt = rep_cnt_q;

endmodule
